// File: rtl/sampleq_multishot_if.sv
// Sample queue bus: front-end samples, frame stream and 8-bit wishbone config.
// The master drives samples, trigger, pulls and register accesses; the slave is the queue.
interface sampleq_multishot_if #(
   parameter int SAMPLE_W = 32,
   parameter int COUNT_W  = 8
);
   logic [SAMPLE_W-1:0] sample;
   logic                sample_avail;
   logic                active;
   logic                trigger;
   logic [SAMPLE_W-1:0] samp_stream_data;
   logic [COUNT_W-1:0]  samp_stream_count;
   logic                samp_stream_avail;
   logic                samp_stream_pull;
   logic                wb_stb_i;
   logic                wb_cyc_i;
   logic                wb_we_i;
   logic [15:0]         wb_adr_i;
   logic [7:0]          wb_dat_i;
   logic [7:0]          wb_dat_o;
   logic                wb_ack_o;

   modport master (
      output sample, sample_avail, trigger, samp_stream_pull,
      output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
      input  active, samp_stream_data, samp_stream_count,
      input  samp_stream_avail, wb_dat_o, wb_ack_o
   );

   modport slave (
      input  sample, sample_avail, trigger, samp_stream_pull,
      input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
      output active, samp_stream_data, samp_stream_count,
      output samp_stream_avail, wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/sampleq_multishot.sv
// Decimating circular sample queue; on trigger streams preface plus post-trigger
// samples, with auto-rearm, overflow stop and wishbone-mapped control.
module sampleq_multishot #(
   parameter int QUEUE_SIZE = 8192,
   parameter int SAMPLE_W   = 32,
   parameter int COUNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sampleq_multishot_if.slave io_bus
);
   localparam int AW = $clog2(QUEUE_SIZE);
   localparam int FW = AW + 1;
   localparam logic [AW-1:0]      LAST     = AW'(QUEUE_SIZE - 1);
   localparam logic [FW-1:0]      OVF_FILL = FW'(QUEUE_SIZE - 2);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

   logic                r_active, r_have_frame, r_en_trig, r_force;
   logic                r_rearm, r_overflow, r_avail;
   logic [15:0]         r_preface, r_decim, r_div;
   logic [31:0]         r_frame_size, r_fifo_pos;
   logic [31:0]         r_push_cnt, r_pull_cnt, r_frame_cnt;
   logic [7:0]          r_frames_done;
   logic [AW-1:0]       r_push_ptr, r_pull_ptr;
   logic [COUNT_W-1:0]  r_count;
   logic [SAMPLE_W-1:0] r_data;
   logic [SAMPLE_W-1:0] r_mem [QUEUE_SIZE];

   logic [FW-1:0] w_fill, w_fill_n;
   logic          w_wr, w_push, w_pull, w_trig, w_ovf, w_hf_n;
   logic [AW-1:0] w_push_ptr_n, w_pull_ptr_n, w_trig_ptr;
   logic [31:0]   w_push_cnt_n, w_pull_cnt_n, w_frame_cnt_n, w_tp, w_min;
   logic [3:0]    w_adr;
   logic [7:0]    w_dat;
   logic          w_unused;

   assign w_adr    = io_bus.wb_adr_i[3:0];
   assign w_dat    = io_bus.wb_dat_i;
   assign w_unused = ^io_bus.wb_adr_i[15:4];
   assign w_wr     = io_bus.wb_stb_i & io_bus.wb_cyc_i & io_bus.wb_we_i;
   assign w_fill   = FW'(r_push_cnt - r_pull_cnt);
   assign w_ovf    = r_have_frame & (w_fill == OVF_FILL);
   assign w_push   = r_active & io_bus.sample_avail & (r_div == '0) & ~w_ovf;
   assign w_pull   = r_avail & io_bus.samp_stream_pull;
   assign w_trig   = r_en_trig & (r_force | io_bus.trigger) & r_active
                   & ~r_have_frame & ~w_pull;
   assign w_tp     = 32'(r_push_ptr) + 32'(QUEUE_SIZE) - 32'(r_preface);
   assign w_trig_ptr = AW'((w_tp >= 32'(QUEUE_SIZE)) ?
                           w_tp - 32'(QUEUE_SIZE) : w_tp);

   // Next-state view so the registered stream flags never lag a pull
   always_comb begin
      w_push_ptr_n  = r_push_ptr;
      w_push_cnt_n  = r_push_cnt;
      w_pull_ptr_n  = r_pull_ptr;
      w_pull_cnt_n  = r_pull_cnt;
      w_frame_cnt_n = r_frame_cnt;
      w_hf_n        = r_have_frame;
      if (w_push) begin
         w_push_ptr_n = (r_push_ptr == LAST) ? '0 : r_push_ptr + AW'(1);
         w_push_cnt_n = r_push_cnt + 32'd1;
      end
      if (w_pull) begin
         w_pull_ptr_n  = (r_pull_ptr == LAST) ? '0 : r_pull_ptr + AW'(1);
         w_pull_cnt_n  = r_pull_cnt + 32'd1;
         w_frame_cnt_n = r_frame_cnt - 32'd1;
      end else if (w_trig) begin
         w_pull_ptr_n  = w_trig_ptr;
         w_pull_cnt_n  = r_push_cnt - 32'(r_preface);
         w_frame_cnt_n = r_frame_size + 32'(r_preface);
         w_hf_n        = 1'b1;
      end
      if (r_have_frame && (r_frame_cnt == '0 || (!r_active && w_fill == '0)))
         w_hf_n = 1'b0;
      w_fill_n = FW'(w_push_cnt_n - w_pull_cnt_n);
      w_min    = (32'(w_fill_n) < w_frame_cnt_n) ? 32'(w_fill_n) : w_frame_cnt_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_active      <= 1'b0;
         r_have_frame  <= 1'b0;
         r_en_trig     <= 1'b0;
         r_force       <= 1'b0;
         r_rearm       <= 1'b0;
         r_overflow    <= 1'b0;
         r_avail       <= 1'b0;
         r_count       <= '0;
         r_preface     <= '0;
         r_decim       <= '0;
         r_div         <= '0;
         r_frame_size  <= '0;
         r_fifo_pos    <= '0;
         r_push_cnt    <= '0;
         r_pull_cnt    <= '0;
         r_frame_cnt   <= '0;
         r_frames_done <= '0;
         r_push_ptr    <= '0;
         r_pull_ptr    <= '0;
      end else begin
         r_push_ptr   <= w_push_ptr_n;
         r_push_cnt   <= w_push_cnt_n;
         r_pull_ptr   <= w_pull_ptr_n;
         r_pull_cnt   <= w_pull_cnt_n;
         r_frame_cnt  <= w_frame_cnt_n;
         r_have_frame <= w_hf_n;
         r_avail      <= w_hf_n & (w_fill_n != '0) & (w_frame_cnt_n != '0);
         r_count      <= !w_hf_n ? '0 :
                         (w_min > 32'(CNT_MAX)) ? CNT_MAX : COUNT_W'(w_min);
         if (r_active && io_bus.sample_avail)
            r_div <= (r_div >= r_decim) ? '0 : r_div + 16'd1;
         if (w_trig) begin
            r_force    <= 1'b0;
            r_fifo_pos <= r_push_cnt;
            if (!r_rearm)
               r_en_trig <= 1'b0;
            if (r_frames_done != 8'hFF)
               r_frames_done <= r_frames_done + 8'd1;
         end
         if (w_wr && w_adr == 4'd0) begin
            r_en_trig <= w_dat[1];
            r_force   <= w_dat[2];
            r_rearm   <= w_dat[3];
            if (w_dat[4])
               r_overflow <= 1'b0;
            if (w_dat[7])
               r_fifo_pos <= r_push_cnt;
            if (r_active || !r_have_frame) begin
               r_active <= w_dat[0];
               if (!r_active && w_dat[0])
                  r_div <= '0;
            end
         end
         if (w_wr && !r_active) begin
            case (w_adr)
               4'd2:    r_preface[7:0]      <= w_dat;
               4'd3:    r_preface[15:8]     <= w_dat;
               4'd4:    r_frame_size[7:0]   <= w_dat;
               4'd5:    r_frame_size[15:8]  <= w_dat;
               4'd6:    r_frame_size[23:16] <= w_dat;
               4'd7:    r_frame_size[31:24] <= w_dat;
               4'd12:   r_decim[7:0]        <= w_dat;
               4'd13:   r_decim[15:8]       <= w_dat;
               default: ;
            endcase
         end
         if (w_ovf) begin
            r_active   <= 1'b0;
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_push_ptr] <= io_bus.sample;
   end

   // Forward the sample being written when it lands on the next read slot
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_data <= '0;
      else if (w_hf_n)
         r_data <= (w_push && r_push_ptr == w_pull_ptr_n) ?
                   io_bus.sample : r_mem[w_pull_ptr_n];
   end

   always_comb begin
      io_bus.wb_dat_o = '0;
      case (w_adr)
         4'd0:  io_bus.wb_dat_o = {r_have_frame, 2'b00, r_overflow,
                                   r_rearm, r_force, r_en_trig, r_active};
         4'd2:  io_bus.wb_dat_o = r_preface[7:0];
         4'd3:  io_bus.wb_dat_o = r_preface[15:8];
         4'd4:  io_bus.wb_dat_o = r_frame_size[7:0];
         4'd5:  io_bus.wb_dat_o = r_frame_size[15:8];
         4'd6:  io_bus.wb_dat_o = r_frame_size[23:16];
         4'd7:  io_bus.wb_dat_o = r_frame_size[31:24];
         4'd8:  io_bus.wb_dat_o = r_fifo_pos[7:0];
         4'd9:  io_bus.wb_dat_o = r_fifo_pos[15:8];
         4'd10: io_bus.wb_dat_o = r_fifo_pos[23:16];
         4'd11: io_bus.wb_dat_o = r_fifo_pos[31:24];
         4'd12: io_bus.wb_dat_o = r_decim[7:0];
         4'd13: io_bus.wb_dat_o = r_decim[15:8];
         4'd14: io_bus.wb_dat_o = r_frames_done;
         default: io_bus.wb_dat_o = '0;
      endcase
   end

   assign io_bus.wb_ack_o          = 1'b1;
   assign io_bus.active            = r_active;
   assign io_bus.samp_stream_avail = r_avail;
   assign io_bus.samp_stream_count = r_count;
   assign io_bus.samp_stream_data  = r_data;
endmodule

// File: tb/tb_sampleq_multishot.sv
// Randomised bench for sampleq_multishot: a sample history queue models the
// stored stream and each frame is checked against the slice the rules select.
module tb_sampleq_multishot;
   localparam int QS = 512;
   localparam int SW = 32;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sampleq_multishot_if #(.SAMPLE_W(SW), .COUNT_W(CW)) bus ();

   sampleq_multishot #(.QUEUE_SIZE(QS), .SAMPLE_W(SW), .COUNT_W(CW)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   int errors = 0;
   int checks = 0;
   logic [SW-1:0] hist[$];
   logic [SW-1:0] got[$];
   int exp_idx[$];

   task automatic idle_inputs();
      bus.sample = '0;
      bus.sample_avail = 1'b0;
      bus.trigger = 1'b0;
      bus.samp_stream_pull = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
      got.delete();
      exp_idx.delete();
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [7:0] d);
      bus.wb_adr_i = {12'd0, a};
      bus.wb_dat_i = d;
      bus.wb_stb_i = 1'b1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_we_i = 1'b1;
      @(negedge clk);
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_we_i = 1'b0;
   endtask

   task automatic wb_read(input logic [3:0] a, output logic [7:0] d);
      bus.wb_adr_i = {12'd0, a};
      bus.wb_stb_i = 1'b1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_we_i = 1'b0;
      #1 d = bus.wb_dat_o;
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
   endtask

   // One clock of stimulus; pulled data is collected into got
   task automatic step(input bit push, input bit store, input bit trig,
                       input bit pull);
      if (pull && bus.samp_stream_avail === 1'b1) begin
         got.push_back(bus.samp_stream_data);
         bus.samp_stream_pull = 1'b1;
      end
      bus.sample = $urandom;
      bus.sample_avail = push;
      bus.trigger = trig;
      if (push && store)
         hist.push_back(bus.sample);
      @(negedge clk);
      bus.samp_stream_pull = 1'b0;
      bus.sample_avail = 1'b0;
      bus.trigger = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      checks++;
      if (bus.samp_stream_avail !== 1'b0 || bus.samp_stream_count !== '0) begin
         errors++;
         $display("FAIL reset_stream avail=%b count=%0d required 0/0",
                  bus.samp_stream_avail, bus.samp_stream_count);
      end
      checks++;
      if (bus.active !== 1'b0 || bus.wb_ack_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_active active=%b ack=%b required 0/1",
                  bus.active, bus.wb_ack_o);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL reset_status got=%h required 00", d);
      end
      wb_read(4'd14, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL reset_frames_done got=%h required 00", d);
      end
   endtask

   task automatic test_basic();
      logic [7:0] d, d2;
      int left, n, nbad;
      do_reset();
      wb_write(4'd2, 8'd4);
      wb_write(4'd4, 8'd10);
      wb_write(4'd0, 8'h03);
      repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
      wb_write(4'd2, 8'd9);
      wb_read(4'd2, d);
      checks++;
      if (d !== 8'd4) begin
         errors++;
         $display("FAIL preface_locked got=%0d required 4", d);
      end
      wb_write(4'd0, 8'h07);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.samp_stream_avail !== 1'b1 || bus.samp_stream_count !== 8'd4) begin
         errors++;
         $display("FAIL basic_trig_count avail=%b count=%0d required 1/4",
                  bus.samp_stream_avail, bus.samp_stream_count);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h81) begin
         errors++;
         $display("FAIL basic_status got=%h required 81", d);
      end
      wb_read(4'd8, d);
      wb_read(4'd14, d2);
      checks++;
      if (d !== 8'd20 || d2 !== 8'd1) begin
         errors++;
         $display("FAIL basic_pos_done pos=%0d done=%0d required 20/1", d, d2);
      end
      left = 10;
      n = 0;
      while (got.size() < 14 && n < 60) begin
         step(left > 0, 1'b1, 1'b0, 1'b1);
         if (left > 0) left--;
         n++;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      nbad = 0;
      for (int k = 0; k < got.size() && k < 14; k++)
         if (got[k] !== hist[16 + k]) nbad++;
      checks++;
      if (got.size() != 14 || nbad != 0) begin
         errors++;
         $display("FAIL basic_frame pulled=%0d bad=%0d required 14 samples 16..29",
                  got.size(), nbad);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h01) begin
         errors++;
         $display("FAIL basic_end_status got=%h required 01", d);
      end
      wb_write(4'h0, 8'h81);
      wb_read(4'd8, d);
      checks++;
      if (d !== 8'(hist.size())) begin
         errors++;
         $display("FAIL snap_pos got=%0d required %0d", d, hist.size());
      end
   endtask

   task automatic test_decim();
      logic [7:0] d;
      int n, nbad;
      do_reset();
      wb_write(4'd12, 8'd2);
      wb_write(4'd2, 8'd10);
      wb_write(4'd0, 8'h01);
      for (int i = 0; i < 30; i++)
         step(1'b1, (i % 3) == 0, 1'b0, 1'b0);
      wb_write(4'd0, 8'h81);
      wb_read(4'd8, d);
      checks++;
      if (d !== 8'd10) begin
         errors++;
         $display("FAIL decim_push_count got=%0d required 10", d);
      end
      wb_write(4'd0, 8'h07);
      n = 0;
      while (got.size() < 10 && n < 40) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      nbad = 0;
      for (int k = 0; k < got.size() && k < 10; k++)
         if (got[k] !== hist[k]) nbad++;
      checks++;
      if (got.size() != 10 || nbad != 0) begin
         errors++;
         $display("FAIL decim_frame pulled=%0d bad=%0d required 10 every-3rd",
                  got.size(), nbad);
      end
   endtask

   task automatic test_rearm();
      logic [7:0] d;
      int nbad;
      bit trig;
      do_reset();
      wb_write(4'd4, 8'd5);
      wb_write(4'd0, 8'h0B);
      for (int c = 0; c < 160; c++) begin
         trig = (c % 50) == 10;
         if (trig)
            for (int k = 0; k < 5; k++) exp_idx.push_back(hist.size() + k);
         step(1'b1, 1'b1, trig, 1'b1);
      end
      nbad = 0;
      for (int k = 0; k < got.size() && k < exp_idx.size(); k++)
         if (exp_idx[k] >= hist.size() || got[k] !== hist[exp_idx[k]]) nbad++;
      checks++;
      if (got.size() != 15 || nbad != 0) begin
         errors++;
         $display("FAIL rearm_stream pulled=%0d bad=%0d required 15", got.size(), nbad);
      end
      wb_read(4'd14, d);
      checks++;
      if (d !== 8'd3) begin
         errors++;
         $display("FAIL rearm_frames_done got=%0d required 3", d);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h0B) begin
         errors++;
         $display("FAIL rearm_status got=%h required 0b", d);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] d, d2;
      int left, n, nbad;
      do_reset();
      wb_write(4'd2, 8'd8);
      wb_write(4'd4, 8'd6);
      wb_write(4'd0, 8'h01);
      repeat (QS - 2) step(1'b1, 1'b1, 1'b0, 1'b0);
      wb_write(4'd0, 8'h03);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      wb_read(4'd8, d);
      wb_read(4'd9, d2);
      checks++;
      if ({d2, d} !== 16'(QS - 2)) begin
         errors++;
         $display("FAIL wrap_pos got=%0d required %0d", {d2, d}, QS - 2);
      end
      left = 6;
      n = 0;
      while (got.size() < 14 && n < 60) begin
         step(left > 0, 1'b1, 1'b0, 1'b1);
         if (left > 0) left--;
         n++;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      nbad = 0;
      for (int k = 0; k < got.size() && k < 14; k++)
         if (got[k] !== hist[QS - 10 + k]) nbad++;
      checks++;
      if (got.size() != 14 || nbad != 0) begin
         errors++;
         $display("FAIL wrap_frame pulled=%0d bad=%0d required 14 from %0d",
                  got.size(), nbad, QS - 10);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] d;
      int n, nbad;
      do_reset();
      wb_write(4'd5, 8'd4);
      wb_write(4'd0, 8'h03);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < QS + 8; i++)
         step(1'b1, hist.size() < QS - 2, 1'b0, 1'b0);
      checks++;
      if (bus.active !== 1'b0 || bus.samp_stream_count !== 8'd255) begin
         errors++;
         $display("FAIL ovf_stop active=%b count=%0d required 0/255",
                  bus.active, bus.samp_stream_count);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h90) begin
         errors++;
         $display("FAIL ovf_status got=%h required 90", d);
      end
      wb_write(4'd0, 8'h01);
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h90) begin
         errors++;
         $display("FAIL ovf_active_locked got=%h required 90", d);
      end
      n = 0;
      while (got.size() < QS - 2 && n < QS + 100) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      nbad = 0;
      for (int k = 0; k < got.size() && k < QS - 2; k++)
         if (got[k] !== hist[k]) nbad++;
      checks++;
      if (got.size() != QS - 2 || nbad != 0) begin
         errors++;
         $display("FAIL ovf_drain pulled=%0d bad=%0d required %0d",
                  got.size(), nbad, QS - 2);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h10) begin
         errors++;
         $display("FAIL ovf_after_drain got=%h required 10", d);
      end
      wb_write(4'd0, 8'h10);
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL ovf_clear got=%h required 00", d);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      do_reset();
      wb_write(4'd2, 8'd4);
      wb_write(4'd4, 8'd10);
      wb_write(4'd0, 8'h03);
      repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
      wb_write(4'd0, 8'h07);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.samp_stream_avail !== 1'b1) begin
         errors++;
         $display("FAIL midframe_setup avail=%b required 1", bus.samp_stream_avail);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.samp_stream_avail !== 1'b0 || bus.samp_stream_count !== '0) begin
         errors++;
         $display("FAIL midframe_reset avail=%b count=%0d required 0/0",
                  bus.samp_stream_avail, bus.samp_stream_count);
      end
      wb_read(4'd0, d);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL midframe_status got=%h required 00", d);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_decim();
      test_rearm();
      test_wrap();
      test_overflow();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
